dmem_responder: RTL and testbench

- Data-memory responder that sits on the far side of the core's load/store interface.
- Accepts one request at a time over a valid/ready handshake and applies programmable wait states.
- Performs RV32I byte/half/word loads and stores into an internal word-organised array.
- Returns load data or an error over a valid/ready response channel.

---
 rtl/dmem_responder.sv | 127 ++++++++++++
 tb/tb_dmem_responder.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: RV32I load/store data memory with programmable wait states and valid/ready channels.
// Optional MMIO cycle counter and LED register enabled by defining DMEM_MMIO_EN.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_size,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [7:0]  mmio_led
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
  localparam logic [3:0] WLOAD = WAIT_STATES == 0 ? 4'd0 : 4'(WAIT_STATES - 1);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        cap_we;
  logic [31:0] cap_addr, cap_wdata;
  logic [2:0]  cap_size;
  logic [31:0] mem [DEPTH_WORDS];

  logic        idle, commit, c_we, size_ok, align_ok, mem_err, err, mmio, mem_we;
  logic [31:0] c_addr, c_wdata, off, word, ld, wd, rdata_n, mmio_rd;
  logic [2:0]  c_size;
  logic [1:0]  lane;
  logic [AW-1:0] idx;
  logic [15:0] sh;
  logic [3:0]  be;

  assign idle       = state == IDLE;
  assign req_ready  = idle;
  assign resp_valid = state == RESP;
  // With zero wait states the commit edge is the accepting edge, so decode straight from the request.
  assign commit  = (idle && req_valid && WAIT_STATES == 0) || (state == WAIT && cnt == 4'd0);
  assign c_we    = idle ? req_we : cap_we;
  assign c_addr  = idle ? req_addr : cap_addr;
  assign c_wdata = idle ? req_wdata : cap_wdata;
  assign c_size  = idle ? req_size : cap_size;

  assign off  = c_addr - BASE_ADDR;
  assign idx  = off[AW+1:2];
  assign lane = c_addr[1:0];
  assign word = mem[idx];
  assign sh   = 16'(word >> {lane, 3'b000});
  assign ld   = c_size == 3'd0 ? {{24{sh[7]}}, sh[7:0]} :
                c_size == 3'd1 ? {{16{sh[15]}}, sh} :
                c_size == 3'd4 ? {24'b0, sh[7:0]} :
                c_size == 3'd5 ? {16'b0, sh} : word;
  assign wd   = c_wdata << {lane, 3'b000};
  assign be   = c_size == 3'd0 ? 4'b0001 << lane : c_size == 3'd1 ? 4'b0011 << lane : 4'b1111;

  assign size_ok  = c_we ? c_size <= 3'd2 : (c_size != 3'd3 && c_size <= 3'd5);
  assign align_ok = c_size[1:0] == 2'd1 ? !c_addr[0] : c_size[1:0] == 2'd2 ? lane == 2'd0 : 1'b1;
  assign mem_err  = !(size_ok && align_ok && off < SPAN);

`ifdef DMEM_MMIO_EN
  logic [31:0] cyc;
  logic        is_cnt, is_led;
  assign is_cnt  = c_addr == 32'hFFFF_FFF0;
  assign is_led  = c_addr == 32'hFFFF_FFF4;
  assign mmio    = is_cnt || is_led;
  assign err     = is_cnt ? (c_we || c_size != 3'd2) : is_led ? c_size != 3'd2 : mem_err;
  assign mmio_rd = is_cnt ? cyc : {24'b0, mmio_led};
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc      <= '0;
      mmio_led <= '0;
    end else begin
      cyc <= cyc + 32'd1;
      if (commit && is_led && c_we && !err) mmio_led <= c_wdata[7:0];
    end
  end
`else
  assign mmio     = 1'b0;
  assign err      = mem_err;
  assign mmio_rd  = '0;
  assign mmio_led = '0;
`endif

  assign rdata_n = (err || c_we) ? 32'd0 : mmio ? mmio_rd : ld;
  assign mem_we  = commit && c_we && !err && !mmio;

  always_ff @(posedge clk) begin
    if (mem_we)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (idle && req_valid) begin
        cap_we    <= req_we;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
        cap_size  <= req_size;
        cnt       <= WLOAD;
        state     <= WAIT_STATES == 0 ? RESP : WAIT;
      end
      if (state == WAIT) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd0) state <= RESP;
      end
      if (commit) begin
        resp_rdata <= rdata_n;
        resp_err   <= err;
      end
      if (state == RESP && resp_ready) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed-vector bench for dmem_responder with WAIT_STATES=2.
module tb_dmem_responder;
  logic        clk = 0, reset = 1, req_valid = 0, req_ready, req_we = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, resp_rdata;
  logic [2:0]  req_size = 0;
  logic        resp_valid, resp_ready = 0, resp_err;
  logic [7:0]  mmio_led;
  int          tests = 0, fails = 0, cyc = 0;
  logic [31:0] rd, rd0, v1;
  logic        er;
  int          lat, t, t1;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err), .mmio_led(mmio_led));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] size);
    @(negedge clk);
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata; req_size = size;
    @(posedge clk);
    #1 req_valid = 0;
  endtask

  task automatic wait_resp();
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (resp_valid) break;
    end
    if (!resp_valid) check("timeout", 0, 1);
    rd = resp_rdata; er = resp_err; t = cyc;
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] size);
    issue(we, addr, wdata, size);
    wait_resp();
    resp_ready = 1;
    @(posedge clk);
    #1 resp_ready = 0;
  endtask

  task automatic expect_ok(input string tag, input logic [31:0] exp);
    check({tag, "_rd"}, rd, exp);
    check({tag, "_err"}, {31'b0, er}, 0);
  endtask

  task automatic expect_err(input string tag);
    check({tag, "_rd"}, rd, 0);
    check({tag, "_err"}, {31'b0, er}, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 0;
    check("rst_req_ready", {31'b0, req_ready}, 1);
    check("rst_resp_valid", {31'b0, resp_valid}, 0);
    check("rst_rdata", resp_rdata, 0);
    check("rst_err", {31'b0, resp_err}, 0);
    check("rst_led", {24'b0, mmio_led}, 0);

    do_req(1, 32'h10, 32'hDEADBEEF, 2); expect_ok("sw10", 0); check("sw10_lat", lat, 3);
    do_req(0, 32'h10, 0, 2);            expect_ok("lw10", 32'hDEADBEEF); check("lw10_lat", lat, 3);
    do_req(1, 32'h12, 32'h55, 0);       expect_ok("sb12", 0);
    do_req(0, 32'h10, 0, 2);            expect_ok("lw10b", 32'hDE55BEEF);
    do_req(0, 32'h13, 0, 0);            expect_ok("lb13", 32'hFFFFFFDE);
    do_req(0, 32'h13, 0, 4);            expect_ok("lbu13", 32'h000000DE);
    do_req(0, 32'h10, 0, 1);            expect_ok("lh10", 32'hFFFFBEEF);
    do_req(0, 32'h12, 0, 5);            expect_ok("lhu12", 32'h0000DE55);
    do_req(1, 32'h0, 32'h11223344, 2);  expect_ok("sw00", 0);

    do_req(0, 32'h11, 0, 2);            expect_err("lw11");
    do_req(1, 32'h13, 32'hFFFF, 1);     expect_err("sh13");
    do_req(0, 32'h400, 0, 2);           expect_err("lw400");
    do_req(1, 32'h400, 32'hAAAAAAAA, 2); expect_err("sw400");
    do_req(0, 32'h10, 0, 2);            expect_ok("lw10c", 32'hDE55BEEF);
    do_req(0, 32'h0, 0, 2);             expect_ok("lw00", 32'h11223344);
    do_req(0, 32'h10, 0, 3);            expect_err("ld_sz3");
    do_req(1, 32'h10, 32'h0, 4);        expect_err("st_sz4");
    do_req(0, 32'h10, 0, 2);            expect_ok("lw10d", 32'hDE55BEEF);

    // Backpressure with a competing store held on the request channel.
    issue(0, 32'h10, 0, 2);
    wait_resp();
    rd0 = resp_rdata;
    check("bp_rd0", rd0, 32'hDE55BEEF);
    req_valid = 1; req_we = 1; req_addr = 32'h10; req_wdata = 0; req_size = 2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", {31'b0, resp_valid}, 1);
      check("bp_rdata", resp_rdata, rd0);
      check("bp_err", {31'b0, resp_err}, 0);
      check("bp_req_ready", {31'b0, req_ready}, 0);
    end
    req_valid = 0; resp_ready = 1;
    @(posedge clk);
    #1 resp_ready = 0;
    do_req(0, 32'h10, 0, 2);            expect_ok("bp_after", 32'hDE55BEEF);

    // Reset while the store sits in WAIT.
    do_req(1, 32'h20, 32'hCAFEF00D, 2); expect_ok("sw20", 0);
    issue(1, 32'h20, 32'h12345678, 2);
    @(negedge clk) reset = 1;
    @(negedge clk) reset = 0;
    check("mid_req_ready", {31'b0, req_ready}, 1);
    check("mid_resp_valid", {31'b0, resp_valid}, 0);
    do_req(0, 32'h20, 0, 2);            expect_ok("lw20", 32'hCAFEF00D);

`ifdef DMEM_MMIO_EN
    do_req(1, 32'hFFFFFFF4, 32'h000000A5, 2); expect_ok("sw_led", 0);
    check("led", {24'b0, mmio_led}, 32'hA5);
    do_req(0, 32'hFFFFFFF4, 0, 2);      expect_ok("lw_led", 32'hA5);
    do_req(0, 32'hFFFFFFF4, 0, 0);      expect_err("lb_led");
    do_req(1, 32'hFFFFFFF0, 32'h1, 2);  expect_err("sw_cnt");
    do_req(0, 32'hFFFFFFF0, 0, 2);      check("cnt1_err", {31'b0, er}, 0);
    v1 = rd; t1 = t;
    repeat (7) @(negedge clk);
    do_req(0, 32'hFFFFFFF0, 0, 2);      check("cnt2_err", {31'b0, er}, 0);
    check("cnt_delta", rd - v1, 32'(t - t1));
`else
    do_req(1, 32'hFFFFFFF4, 32'h000000A5, 2); expect_err("sw_led");
    check("led", {24'b0, mmio_led}, 0);
    do_req(0, 32'hFFFFFFF0, 0, 2);      expect_err("lw_cnt");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
